// File: rtl/regfile_wb_arbiter_if.sv
// Write-port bus of the register file front end: ALU and load result streams in,
// registered write port and pending mask out.
interface regfile_wb_arbiter_if;
    logic        AluValid;
    logic [4:0]  AluRd;
    logic [31:0] AluData;
    logic        AluStall;
    logic        LdValid;
    logic        LdReady;
    logic [4:0]  LdRd;
    logic [31:0] LdData;
    logic [4:0]  RD;
    logic [31:0] Din;
    logic        WE;
    logic [31:0] Pending;

    modport slave (
        input  AluValid, AluRd, AluData, LdValid, LdRd, LdData,
        output AluStall, LdReady, RD, Din, WE, Pending
    );

    modport master (
        output AluValid, AluRd, AluData, LdValid, LdRd, LdData,
        input  AluStall, LdReady, RD, Din, WE, Pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-side front end of the 32x32 register file: merges ALU and load results onto one
// registered write port, buffering loads in a FIFO and bounding how long they can starve.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic                 Clk,
    input logic                 Rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] ST_NORMAL      = 1'b0;
    localparam logic [0:0] ST_FORCE_DRAIN = 1'b1;

    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [4:0]    fifo_rd_d   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [0:0]    state_q, state_d;
    logic          we_q, we_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   din_q, din_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          ld_ready;
    logic          ld_keep;
    logic          alu_win;
    logic          force_win;
    logic          do_push;
    logic          do_pop;
    logic          alu_stall;
    logic [PW-1:0] slot_off;
    logic [31:0]   pending;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign ld_ready   = !Rst && !fifo_full;
    // x0 loads complete the handshake but are dropped here.
    assign ld_keep    = bus.LdValid && ld_ready && (bus.LdRd != 5'd0);
    assign alu_win    = bus.AluValid && (bus.AluRd != 5'd0);
    assign force_win  = (state_q == ST_FORCE_DRAIN) && !fifo_empty;

    always_comb begin
        do_push   = 1'b0;
        do_pop    = 1'b0;
        alu_stall = 1'b0;
        we_d      = 1'b0;
        rd_d      = rd_q;
        din_d     = din_q;
        if (force_win) begin
            do_pop    = 1'b1;
            do_push   = ld_keep;
            alu_stall = bus.AluValid;
            we_d      = 1'b1;
            rd_d      = fifo_rd_q[rd_ptr_q];
            din_d     = fifo_data_q[rd_ptr_q];
        end else if (alu_win) begin
            do_push = ld_keep;
            we_d    = 1'b1;
            rd_d    = bus.AluRd;
            din_d   = bus.AluData;
        end else if (!fifo_empty) begin
            do_pop  = 1'b1;
            do_push = ld_keep;
            we_d    = 1'b1;
            rd_d    = fifo_rd_q[rd_ptr_q];
            din_d   = fifo_data_q[rd_ptr_q];
        end else if (ld_keep) begin
            we_d  = 1'b1;
            rd_d  = bus.LdRd;
            din_d = bus.LdData;
        end
    end

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (do_push) begin
            fifo_rd_d[wr_ptr_q]   = bus.LdRd;
            fifo_data_d[wr_ptr_q] = bus.LdData;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Only ALU wins over a non-empty FIFO extend the streak; anything else restarts it.
    always_comb begin
        state_d  = ST_NORMAL;
        starve_d = '0;
        if (state_q == ST_NORMAL) begin
            if (alu_win && !fifo_empty) begin
                starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
            end
            if (starve_d == SW'(STARVE_LIMIT)) begin
                state_d = ST_FORCE_DRAIN;
            end
        end
    end

    always_comb begin
        pending  = '0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PW'(i) - rd_ptr_q;
            if (CW'(slot_off) < count_q) begin
                pending = pending | (32'd1 << fifo_rd_q[i]);
            end
        end
        if (we_q) begin
            pending = pending | (32'd1 << rd_q);
        end
    end

    assign bus.LdReady  = ld_ready;
    assign bus.AluStall = alu_stall && !Rst;
    assign bus.RD       = rd_q;
    assign bus.Din      = din_q;
    assign bus.WE       = we_q;
    assign bus.Pending  = Rst ? 32'd0 : (pending & ~32'd1);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            state_q  <= ST_NORMAL;
            we_q     <= 1'b0;
            rd_q     <= '0;
            din_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            state_q  <= state_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            din_q    <= din_d;
        end
    end

    // Entry storage needs no reset: only slots covered by the count are ever read.
    always_ff @(posedge Clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a behavioural arbiter model predicts each
// write into a scoreboard queue that is drained as the DUT raises WE.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         m_q[$];
    wr_t         exp_q[$];
    int          m_cnt    = 0;
    bit          m_force  = 1'b0;
    bit          m_we     = 1'b0;
    logic [4:0]  m_rd     = '0;
    logic [31:0] m_din    = '0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drives one cycle of inputs, checks the DUT against the model state, then advances the model.
    task automatic applyStimulus(input bit rst, input bit av, input logic [4:0] ard, input logic [31:0] adata,
                                 input bit lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                 output bit stall_o, output bit acc_o);
        wr_t         w;
        bit          has_w;
        bit          acc;
        bit          bypass;
        bit          alu_rule;
        bit          was_nonempty;
        bit          stall_m;
        logic [31:0] pend_m;

        Rst          = rst;
        bus.AluValid = av;
        bus.AluRd    = ard;
        bus.AluData  = adata;
        bus.LdValid  = lv;
        bus.LdRd     = lrd;
        bus.LdData   = ldata;
        #1;

        checkOutput("we", 32'(bus.WE), 32'(m_we));
        checkOutput("rd", 32'(bus.RD), 32'(m_rd));
        checkOutput("din", bus.Din, m_din);
        pend_m = '0;
        if (!rst) begin
            for (int i = 0; i < m_q.size(); i++) pend_m = pend_m | (32'd1 << m_q[i].rd);
            if (m_we) pend_m = pend_m | (32'd1 << m_rd);
            pend_m = pend_m & ~32'd1;
        end
        checkOutput("pending", bus.Pending, pend_m);
        checkOutput("ld_ready", 32'(bus.LdReady), 32'(!rst && (m_q.size() < DEPTH)));

        stall_o = 1'b0;
        acc_o   = 1'b0;
        if (rst) begin
            checkOutput("alu_stall_rst", 32'(bus.AluStall), 32'd0);
            m_q.delete();
            m_cnt   = 0;
            m_force = 1'b0;
            m_we    = 1'b0;
            m_rd    = '0;
            m_din   = '0;
            return;
        end

        acc          = lv && (m_q.size() < DEPTH);
        was_nonempty = (m_q.size() > 0);
        has_w        = 1'b0;
        bypass       = 1'b0;
        alu_rule     = 1'b0;
        stall_m      = 1'b0;
        w            = '0;
        if (m_force && was_nonempty) begin
            w       = m_q.pop_front();
            has_w   = 1'b1;
            stall_m = av;
        end else if (av && ard != 5'd0) begin
            w        = '{rd: ard, data: adata};
            has_w    = 1'b1;
            alu_rule = 1'b1;
        end else if (was_nonempty) begin
            w     = m_q.pop_front();
            has_w = 1'b1;
        end else if (acc && lrd != 5'd0) begin
            w      = '{rd: lrd, data: ldata};
            has_w  = 1'b1;
            bypass = 1'b1;
        end
        if (acc && lrd != 5'd0 && !bypass) m_q.push_back('{rd: lrd, data: ldata});

        if (m_force) begin
            m_force = 1'b0;
            m_cnt   = 0;
        end else begin
            if (alu_rule && was_nonempty) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : m_cnt;
            else m_cnt = 0;
            m_force = (m_cnt == LIMIT);
        end

        checkOutput("alu_stall", 32'(bus.AluStall), 32'(stall_m));
        if (has_w) begin
            exp_q.push_back(w);
            m_rd  = w.rd;
            m_din = w.data;
        end
        m_we    = has_w;
        stall_o = stall_m;
        acc_o   = acc;
    endtask

    always @(negedge Clk) begin
        if (bus.WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("wr_unexpected", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("wr_rd", 32'(bus.RD), 32'(e.rd));
                checkOutput("wr_din", bus.Din, e.data);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit          st;
        bit          ac;
        int          accepted;
        bit          stall_prev;
        bit          cur_av;
        logic [4:0]  cur_ard;
        logic [31:0] cur_adata;
        logic [31:0] seq;

        Rst          = 1'b1;
        bus.AluValid = 1'b0;
        bus.AluRd    = '0;
        bus.AluData  = '0;
        bus.LdValid  = 1'b1;
        bus.LdRd     = 5'd5;
        bus.LdData   = 32'h55;
        tick();

        // T1: second reset cycle with a load offered, then release.
        applyStimulus(1, 0, 5'd0, 32'd0, 1, 5'd5, 32'h55, st, ac);
        checkOutput("t1_ldready_rst", 32'(bus.LdReady), 32'd0);
        checkOutput("t1_pending_rst", bus.Pending, 32'd0);
        tick();
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, st, ac);
        checkOutput("t1_ldready_rel", 32'(bus.LdReady), 32'd1);
        tick();

        // T2: ALU path and an x0 ALU result.
        applyStimulus(0, 1, 5'd1, 32'd10, 0, 5'd0, 32'd0, st, ac);
        tick();
        checkOutput("t2_we", 32'(bus.WE), 32'd1);
        checkOutput("t2_rd", 32'(bus.RD), 32'd1);
        checkOutput("t2_din", bus.Din, 32'd10);
        checkOutput("t2_pending", bus.Pending, 32'h2);
        applyStimulus(0, 1, 5'd0, 32'd99, 0, 5'd0, 32'd0, st, ac);
        checkOutput("t2_x0_stall", 32'(bus.AluStall), 32'd0);
        tick();
        checkOutput("t2_x0_we", 32'(bus.WE), 32'd0);

        // T3: load bypass into an empty FIFO.
        applyStimulus(0, 0, 5'd0, 32'd0, 1, 5'd2, 32'hDEAD, st, ac);
        checkOutput("t3_ldready", 32'(bus.LdReady), 32'd1);
        tick();
        checkOutput("t3_we", 32'(bus.WE), 32'd1);
        checkOutput("t3_rd", 32'(bus.RD), 32'd2);
        checkOutput("t3_din", bus.Din, 32'hDEAD);
        checkOutput("t3_pending", bus.Pending, 32'h4);

        // T4: ALU contention fills the FIFO, then starvation forces one drain.
        accepted = 0;
        for (int c = 0; c <= 10; c++) begin
            applyStimulus(0, 1, 5'd1, 32'h100 + 32'(c), 1, (accepted < 4) ? 5'(3 + accepted) : 5'd7,
                          32'hA000 + 32'(accepted), st, ac);
            if (c == 4) begin
                checkOutput("t4_ldready_full", 32'(bus.LdReady), 32'd0);
                checkOutput("t4_pend_loads", 32'(bus.Pending[6:3]), 32'hF);
            end
            if (c == 8) checkOutput("t4_no_stall_yet", 32'(bus.AluStall), 32'd0);
            if (c == 9) checkOutput("t4_stall", 32'(bus.AluStall), 32'd1);
            if (c == 10) checkOutput("t4_ldready_again", 32'(bus.LdReady), 32'd1);
            if (ac) accepted++;
            tick();
            if (c == 9) begin
                checkOutput("t4_drain_we", 32'(bus.WE), 32'd1);
                checkOutput("t4_drain_rd", 32'(bus.RD), 32'd3);
                checkOutput("t4_drain_din", bus.Din, 32'hA000);
            end
        end
        for (int c = 0; c < 3 * DEPTH && m_q.size() > 0; c++) begin
            applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, st, ac);
            tick();
        end

        // T5: x0 load, then reset with loads queued.
        applyStimulus(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hBAD0, st, ac);
        checkOutput("t5_x0_ready", 32'(bus.LdReady), 32'd1);
        tick();
        checkOutput("t5_x0_we", 32'(bus.WE), 32'd0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 1, 5'd1, 32'h200 + 32'(c), 1, 5'(8 + c), 32'hB000 + 32'(c), st, ac);
            tick();
        end
        checkOutput("t5_pend_queued", 32'(bus.Pending[10:8]), 32'h7);
        applyStimulus(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, st, ac);
        tick();
        checkOutput("t5_pending_cleared", bus.Pending, 32'd0);
        checkOutput("t5_we_cleared", 32'(bus.WE), 32'd0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, st, ac);
            tick();
            checkOutput("t5_no_write", 32'(bus.WE), 32'd0);
        end

        // Random traffic with ALU hold on stall and occasional resets.
        stall_prev = 1'b0;
        cur_av     = 1'b0;
        cur_ard    = '0;
        cur_adata  = '0;
        seq        = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            bit r;
            r = ($urandom_range(0, 79) == 0);
            if (!stall_prev) begin
                cur_av    = ($urandom_range(0, 9) < 8);
                cur_ard   = 5'($urandom_range(0, 7));
                cur_adata = seq;
                seq++;
            end
            applyStimulus(r, cur_av, cur_ard, cur_adata, $urandom_range(0, 1) == 1,
                          5'($urandom_range(0, 9)), $urandom, st, ac);
            stall_prev = st;
            tick();
        end

        for (int c = 0; c < 3 * DEPTH && m_q.size() > 0; c++) begin
            applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, st, ac);
            tick();
        end
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, st, ac);
        tick();
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, st, ac);
        @(negedge Clk);
        #1;
        checkOutput("final_pending", bus.Pending, 32'd0);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
